// File: rtl/imem_loader_if.sv
// Host-side load port of the instruction-memory loader: byte stream in,
// memory write strobe, and the CPU hold/status outputs.
interface imem_loader_if #(parameter int ADDR_W = 8);
  logic              start;
  logic [7:0]        in_byte;
  logic              in_valid;
  logic              in_ready;
  logic              out_we;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;

  modport master (
    output start, in_byte, in_valid,
    input  in_ready, out_we, out_addr, out_wdata, cpu_hold, done, error
  );

  modport slave (
    input  start, in_byte, in_valid,
    output in_ready, out_we, out_addr, out_wdata, cpu_hold, done, error
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory
// as little-endian 32-bit words, holding the CPU until the image verifies.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input logic         clk,
  input logic         reset,
  imem_loader_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, CSUM, DONE, ERROR} state_t;

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  state_t          state;
  logic [15:0]     len;
  logic [ADDR_W:0] word_idx;
  logic [1:0]      byte_idx;
  logic [7:0]      csum;
  logic [23:0]     shift;

  logic        xfer;
  logic [15:0] len_next;
  logic [16:0] idx_inc;

  assign xfer     = bus.in_valid & bus.in_ready;
  assign len_next = {bus.in_byte, len[7:0]};
  assign idx_inc  = 17'(word_idx) + 17'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      len           <= '0;
      word_idx      <= '0;
      byte_idx      <= '0;
      csum          <= '0;
      shift         <= '0;
      bus.in_ready  <= 1'b0;
      bus.out_we    <= 1'b0;
      bus.out_addr  <= '0;
      bus.out_wdata <= '0;
      bus.cpu_hold  <= 1'b1;
      bus.done      <= 1'b0;
      bus.error     <= 1'b0;
    end else begin
      bus.out_we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state        <= LEN0;
            word_idx     <= '0;
            byte_idx     <= '0;
            csum         <= '0;
            bus.done     <= 1'b0;
            bus.cpu_hold <= 1'b1;
            bus.in_ready <= 1'b1;
          end
        end
        LEN0: begin
          if (xfer) begin
            len[7:0] <= bus.in_byte;
            state    <= LEN1;
          end
        end
        LEN1: begin
          if (xfer) begin
            len[15:8] <= bus.in_byte;
            if ({1'b0, len_next} > MAX_WORDS) begin
              state        <= ERROR;
              bus.in_ready <= 1'b0;
              bus.error    <= 1'b1;
            end else if (len_next == 16'd0) begin
              state <= CSUM;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (xfer) begin
            shift    <= {bus.in_byte, shift[23:8]};
            csum     <= csum ^ bus.in_byte;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              // Strobe is issued while in WRITE, so it lasts exactly one cycle.
              state         <= WRITE;
              bus.in_ready  <= 1'b0;
              bus.out_we    <= 1'b1;
              bus.out_addr  <= word_idx[ADDR_W-1:0];
              bus.out_wdata <= {bus.in_byte, shift};
            end
          end
        end
        WRITE: begin
          word_idx     <= word_idx + 1'b1;
          bus.in_ready <= 1'b1;
          state        <= (idx_inc == {1'b0, len}) ? CSUM : DATA;
        end
        CSUM: begin
          if (xfer) begin
            bus.in_ready <= 1'b0;
            if (bus.in_byte == csum) begin
              state        <= DONE;
              bus.done     <= 1'b1;
              bus.cpu_hold <= 1'b0;
            end else begin
              state     <= ERROR;
              bus.error <= 1'b1;
            end
          end
        end
        ERROR: begin
          bus.in_ready <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Table vectors plus randomized streams checked against a stream-level model.
module tb_imem_loader;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(AW)) bus();
  imem_loader #(.ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]    stim[$];
  logic [AW-1:0] got_a[$];
  logic [31:0]   got_d[$];
  logic [31:0]   exp_w[$];
  bit            exp_err;
  int            exp_used;

  typedef struct packed {
    logic [95:0] bytes;   // stream, first byte in the top octet
    logic [3:0]  nb;
    logic        err;
    logic [1:0]  nw;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  always @(negedge clk) begin
    if (bus.out_we) begin
      got_a.push_back(bus.out_addr);
      got_d.push_back(bus.out_wdata);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Expected result straight from the stream format rules.
  task automatic model();
    int n;
    logic [7:0] x;
    exp_w.delete();
    n = int'({stim[1], stim[0]});
    if (n > (1 << AW)) begin
      exp_err = 1'b1;
      exp_used = 2;
      return;
    end
    x = 8'h00;
    for (int i = 0; i < n; i++) begin
      exp_w.push_back({stim[2+4*i+3], stim[2+4*i+2], stim[2+4*i+1], stim[2+4*i]});
      for (int k = 0; k < 4; k++) x ^= stim[2+4*i+k];
    end
    exp_used = 2 + 4*n + 1;
    exp_err  = (stim[2+4*n] != x);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".in_ready"},  {31'd0, bus.in_ready}, 32'd0);
    chk({tag, ".out_we"},    {31'd0, bus.out_we},   32'd0);
    chk({tag, ".out_addr"},  32'(bus.out_addr),     32'd0);
    chk({tag, ".out_wdata"}, bus.out_wdata,         32'd0);
    chk({tag, ".cpu_hold"},  {31'd0, bus.cpu_hold}, 32'd1);
    chk({tag, ".done"},      {31'd0, bus.done},     32'd0);
    chk({tag, ".error"},     {31'd0, bus.error},    32'd0);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    bus.start = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    got_a.delete();
    got_d.delete();
  endtask

  task automatic drive(input int n, input int gapmax);
    int g;
    bit acc;
    for (int i = 0; i < n; i++) begin
      g = (gapmax == 0) ? 0 : int'($urandom_range(0, gapmax));
      if (g > 0) begin
        bus.in_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
      end
      bus.in_byte = stim[i];
      bus.in_valid = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 100 && !acc; t++) begin
        @(negedge clk);
        if (bus.in_ready) acc = 1'b1;
      end
      @(posedge clk); #1;
      if (!acc) begin
        vectors++;
        miscompares++;
        $display("FAIL accept_timeout: byte %0d never accepted, expected accept", i);
        bus.in_valid = 1'b0;
        return;
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_result(input string tag);
    chk({tag, ".nwrites"}, 32'(got_a.size()), 32'(exp_w.size()));
    for (int i = 0; i < exp_w.size() && i < got_a.size(); i++) begin
      chk({tag, ".addr"}, 32'(got_a[i]), 32'(i));
      chk({tag, ".data"}, got_d[i], exp_w[i]);
    end
    chk({tag, ".done"},     {31'd0, bus.done},     {31'd0, !exp_err});
    chk({tag, ".error"},    {31'd0, bus.error},    {31'd0, exp_err});
    chk({tag, ".cpu_hold"}, {31'd0, bus.cpu_hold}, {31'd0, exp_err});
    chk({tag, ".in_ready"}, {31'd0, bus.in_ready}, 32'd0);
  endtask

  task automatic session(input string tag, input int gapmax);
    if (bus.error) do_reset();
    model();
    pulse_start();
    chk({tag, ".ready_after_start"}, {31'd0, bus.in_ready}, 32'd1);
    drive(exp_used, gapmax);
    check_result(tag);
  endtask

  vec_t tbl[6];
  logic [31:0] v_w[2];

  initial begin
    tbl[0] = '{96'h0200_1300_0000_7856_3412_1B00, 4'd11, 1'b0, 2'd2, 32'h0000_0013, 32'h1234_5678};
    tbl[1] = '{96'h0200_1300_0000_7856_3412_1C00, 4'd11, 1'b1, 2'd2, 32'h0000_0013, 32'h1234_5678};
    tbl[2] = '{96'h0000_0000_0000_0000_0000_0000, 4'd3,  1'b0, 2'd0, 32'h0, 32'h0};
    tbl[3] = '{96'h0000_0100_0000_0000_0000_0000, 4'd3,  1'b1, 2'd0, 32'h0, 32'h0};
    tbl[4] = '{96'h0101_0000_0000_0000_0000_0000, 4'd2,  1'b1, 2'd0, 32'h0, 32'h0};
    tbl[5] = '{96'h0100_FFFF_FFFF_0000_0000_0000, 4'd7,  1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0};

    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_byte = 8'h00;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_reset_vals("reset");

    // Table vectors: expectations are the hand-derived constants.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      stim.delete();
      for (int i = 0; i < int'(tbl[v].nb); i++) stim.push_back(tbl[v].bytes[95-8*i -: 8]);
      exp_w.delete();
      v_w[0] = tbl[v].w0;
      v_w[1] = tbl[v].w1;
      for (int i = 0; i < int'(tbl[v].nw); i++) exp_w.push_back(v_w[i]);
      exp_err = tbl[v].err;
      pulse_start();
      drive(int'(tbl[v].nb), 0);
      check_result($sformatf("tbl%0d", v));
      if (tbl[v].err) begin
        pulse_start();
        chk($sformatf("tbl%0d.err_sticky", v), {31'd0, bus.error}, 32'd1);
        chk($sformatf("tbl%0d.err_ready", v),  {31'd0, bus.in_ready}, 32'd0);
      end
    end

    // Full-depth load: N = 256 words.
    do_reset();
    stim.delete();
    stim.push_back(8'h00);
    stim.push_back(8'h01);
    for (int i = 0; i < 1024; i++) stim.push_back(8'($urandom));
    begin
      logic [7:0] x = 8'h00;
      for (int i = 2; i < 1026; i++) x ^= stim[i];
      stim.push_back(x);
    end
    session("full256", 0);

    // Reset in the middle of a session, with start and a byte offered.
    do_reset();
    stim.delete();
    for (int i = 0; i < 11; i++) stim.push_back(tbl[0].bytes[95-8*i -: 8]);
    pulse_start();
    drive(6, 0);
    reset = 1'b1;
    bus.start = 1'b1;
    bus.in_byte = stim[6];
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    check_reset_vals("midreset");
    session("after_reset", 0);

    // Known stream with random in_valid gaps.
    session("gaps", 5);

    // Random streams: restarts from DONE, bad checksums, oversize lengths.
    for (int r = 0; r < 20; r++) begin
      int n;
      logic [7:0] x;
      stim.delete();
      n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(257, 600)) : int'($urandom_range(0, 8));
      stim.push_back(8'(n));
      stim.push_back(8'(n >> 8));
      x = 8'h00;
      if (n <= 256) begin
        for (int i = 0; i < 4*n; i++) begin
          stim.push_back(8'($urandom));
          x ^= stim[stim.size()-1];
        end
        if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
        stim.push_back(x);
      end
      session($sformatf("rand%0d", r), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
